// File: rtl/sobel_window_3x3.sv
// 3x3 sliding window generator for the Sobel stage: two line buffers plus a 3x3 shift array.
// Define SOBEL_WIN_OUTREG_EN to add an output register stage (2-cycle latency).
module sobel_window_3x3 #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int PIX_W = 12
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     sof,
    input  logic                     pix_valid,
    input  logic [PIX_W-1:0]         pix_data,
    output logic [PIX_W-1:0]         data00,
    output logic [PIX_W-1:0]         data01,
    output logic [PIX_W-1:0]         data02,
    output logic [PIX_W-1:0]         data10,
    output logic [PIX_W-1:0]         data11,
    output logic [PIX_W-1:0]         data12,
    output logic [PIX_W-1:0]         data20,
    output logic [PIX_W-1:0]         data21,
    output logic [PIX_W-1:0]         data22,
    output logic                     win_valid,
    output logic [$clog2(IMG_W)-1:0] win_x,
    output logic [$clog2(IMG_H)-1:0] win_y
);

    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

    logic [XW-1:0] col, cur_col, nxt_col;
    logic [YW-1:0] row, cur_row, nxt_row;
    logic          win_hit;

    logic [PIX_W-1:0] lb0 [IMG_W];
    logic [PIX_W-1:0] lb1 [IMG_W];
    logic [PIX_W-1:0] lb0_rd, lb1_rd;

    // sh[row][col]: row 0 = oldest line, col 2 = newest column
    logic [2:0][2:0][PIX_W-1:0] sh;
    logic                       v1;
    logic [XW-1:0]              x1;
    logic [YW-1:0]              y1;

    logic [2:0][2:0][PIX_W-1:0] taps;
    logic                       vo;
    logic [XW-1:0]              xo;
    logic [YW-1:0]              yo;

    // sof relocates the current pixel to (0,0) before any use of the position
    always_comb begin
        cur_col = sof ? '0 : col;
        cur_row = sof ? '0 : row;
        nxt_col = cur_col + XW'(1);
        nxt_row = cur_row;
        if (cur_col == X_LAST) begin
            nxt_col = '0;
            nxt_row = (cur_row == Y_LAST) ? '0 : cur_row + YW'(1);
        end
        win_hit = pix_valid && (cur_row >= YW'(2)) && (cur_col >= XW'(2));
        lb0_rd  = lb0[cur_col];
        lb1_rd  = lb1[cur_col];
    end

    always_ff @(posedge clk) begin
        if (pix_valid) begin
            lb0[cur_col] <= lb1_rd;
            lb1[cur_col] <= pix_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            col <= '0;
            row <= '0;
            sh  <= '0;
            v1  <= 1'b0;
            x1  <= '0;
            y1  <= '0;
        end else begin
            v1 <= win_hit;
            if (pix_valid) begin
                col <= nxt_col;
                row <= nxt_row;
                for (int unsigned i = 0; i < 3; i++) begin
                    sh[i][0] <= sh[i][1];
                    sh[i][1] <= sh[i][2];
                end
                sh[0][2] <= lb0_rd;
                sh[1][2] <= lb1_rd;
                sh[2][2] <= pix_data;
            end
            if (win_hit) begin
                x1 <= cur_col - XW'(1);
                y1 <= cur_row - YW'(1);
            end
        end
    end

`ifdef SOBEL_WIN_OUTREG_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            taps <= '0;
            vo   <= 1'b0;
            xo   <= '0;
            yo   <= '0;
        end else begin
            taps <= sh;
            vo   <= v1;
            xo   <= x1;
            yo   <= y1;
        end
    end
`else
    always_comb begin
        taps = sh;
        vo   = v1;
        xo   = x1;
        yo   = y1;
    end
`endif

    always_comb begin
        data00    = taps[0][0];
        data01    = taps[0][1];
        data02    = taps[0][2];
        data10    = taps[1][0];
        data11    = taps[1][1];
        data12    = taps[1][2];
        data20    = taps[2][0];
        data21    = taps[2][1];
        data22    = taps[2][2];
        win_valid = vo;
        win_x     = xo;
        win_y     = yo;
    end

endmodule
